// File: rtl/friscv_regfile_sb.sv
// friscv_regfile_sb: multi-port register file with an issue scoreboard (pending bits).
// Optional macro FRISCV_REGFILE_BYPASS_EN forwards same-cycle writes to reads and issue_ready.
module friscv_regfile_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NB_REG   = 32,
  parameter int unsigned NB_WPORT = 2,
  parameter int unsigned NB_RPORT = 4
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       srst,
  input  logic [NB_RPORT*5-1:0]      rs_addr,
  output logic [NB_RPORT*XLEN-1:0]   rs_val,
  input  logic [NB_WPORT-1:0]        wr_valid,
  input  logic [NB_WPORT*5-1:0]      wr_addr,
  input  logic [NB_WPORT*XLEN-1:0]   wr_data,
  input  logic [NB_WPORT*XLEN/8-1:0] wr_strb,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic [4:0]                 issue_rs1,
  input  logic [4:0]                 issue_rs2,
  input  logic [4:0]                 issue_rd,
  input  logic                       issue_rd_en,
  output logic [NB_REG-1:0]          pending,
  output logic                       wr_collision,
  output logic                       addr_error,
  output logic [NB_REG*XLEN-1:0]     regs_flat
);

  localparam int unsigned NBYTE    = XLEN / 8;
  localparam int unsigned AW       = $clog2(NB_REG);
  localparam logic [5:0]  NB_REG_W = 6'(NB_REG);

  logic [XLEN-1:0]     regs_q [NB_REG];
  logic [NB_REG-1:0]   pending_q, pending_d, clr_mask, set_mask, pend_view;
  logic                collision_q, collision_d, addr_err_q, addr_err_d;
  logic [NB_WPORT-1:0] wr_acc;
  logic [XLEN-1:0]     wr_merged [NB_WPORT];

  function automatic logic in_range(input logic [4:0] a);
    return {1'b0, a} < NB_REG_W;
  endfunction

  // Write arbitration: lowest port wins a shared address; x0 and out-of-range writes drop.
  always_comb begin
    wr_acc      = '0;
    collision_d = 1'b0;
    addr_err_d  = 1'b0;
    clr_mask    = '0;
    for (int i = 0; i < NB_WPORT; i++) begin
      if (wr_valid[i]) begin
        if (!in_range(wr_addr[i*5 +: 5])) begin
          addr_err_d = 1'b1;
        end else if (wr_addr[i*5 +: 5] != 5'd0) begin
          wr_acc[i] = 1'b1;
          for (int j = 0; j < i; j++) begin
            if (wr_valid[j] && (wr_addr[j*5 +: 5] == wr_addr[i*5 +: 5])) begin
              wr_acc[i]   = 1'b0;
              collision_d = 1'b1;
            end
          end
        end
      end
      if (wr_acc[i]) clr_mask[wr_addr[i*5 +: AW]] = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NB_WPORT; i++) begin
      for (int b = 0; b < NBYTE; b++) begin
        wr_merged[i][b*8 +: 8] = wr_strb[i*NBYTE + b] ? wr_data[i*XLEN + b*8 +: 8]
                                                     : regs_q[wr_addr[i*5 +: AW]][b*8 +: 8];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NB_RPORT; p++) begin
      rs_val[p*XLEN +: XLEN] = '0;
      if (in_range(rs_addr[p*5 +: 5])) rs_val[p*XLEN +: XLEN] = regs_q[rs_addr[p*5 +: AW]];
`ifdef FRISCV_REGFILE_BYPASS_EN
      for (int i = 0; i < NB_WPORT; i++) begin
        if (wr_acc[i] && (wr_addr[i*5 +: 5] == rs_addr[p*5 +: 5])) begin
          rs_val[p*XLEN +: XLEN] = wr_merged[i];
        end
      end
`endif
    end
  end

  // issue_ready never looks at issue_valid, so the handshake has no combinational loop.
  always_comb begin
`ifdef FRISCV_REGFILE_BYPASS_EN
    pend_view = pending_q & ~clr_mask;
`else
    pend_view = pending_q;
`endif
    issue_ready = 1'b0;
    if (in_range(issue_rs1) && in_range(issue_rs2) && in_range(issue_rd)) begin
      issue_ready = !pend_view[issue_rs1[AW-1:0]] && !pend_view[issue_rs2[AW-1:0]] &&
                    (!issue_rd_en || !pend_view[issue_rd[AW-1:0]]);
    end
  end

  always_comb begin
    set_mask = '0;
    if (issue_valid && issue_ready && issue_rd_en && (issue_rd != 5'd0)) begin
      set_mask[issue_rd[AW-1:0]] = 1'b1;
    end
    // Set has priority over a same-cycle clear.
    pending_d    = (pending_q & ~clr_mask) | set_mask;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int k = 0; k < NB_REG; k++) regs_q[k] <= '0;
      pending_q   <= '0;
      collision_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else if (srst) begin
      for (int k = 0; k < NB_REG; k++) regs_q[k] <= '0;
      pending_q   <= '0;
      collision_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NB_WPORT; i++) begin
        if (wr_acc[i]) regs_q[wr_addr[i*5 +: AW]] <= wr_merged[i];
      end
      pending_q   <= pending_d;
      collision_q <= collision_d;
      addr_err_q  <= addr_err_d;
    end
  end

  for (genvar k = 0; k < NB_REG; k++) begin : g_flat
    assign regs_flat[k*XLEN +: XLEN] = regs_q[k];
  end

  assign pending      = pending_q;
  assign wr_collision = collision_q;
  assign addr_error   = addr_err_q;

endmodule

// File: tb/tb_friscv_regfile_sb.sv
// Self-checking bench for friscv_regfile_sb: directed scenarios then random traffic
// against a behavioural model of registers, pending bits and error flags.
module tb_friscv_regfile_sb;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NB_REG   = 16;
  localparam int unsigned NB_WPORT = 2;
  localparam int unsigned NB_RPORT = 4;
  localparam int unsigned W        = NB_REG * XLEN;
`ifdef FRISCV_REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                       aclk = 1'b0;
  logic                       aresetn = 1'b0;
  logic                       srst;
  logic [NB_RPORT*5-1:0]      rs_addr;
  logic [NB_RPORT*XLEN-1:0]   rs_val;
  logic [NB_WPORT-1:0]        wr_valid;
  logic [NB_WPORT*5-1:0]      wr_addr;
  logic [NB_WPORT*XLEN-1:0]   wr_data;
  logic [NB_WPORT*XLEN/8-1:0] wr_strb;
  logic                       issue_valid, issue_ready, issue_rd_en;
  logic [4:0]                 issue_rs1, issue_rs2, issue_rd;
  logic [NB_REG-1:0]          pending;
  logic                       wr_collision, addr_error;
  logic [W-1:0]               regs_flat;

  friscv_regfile_sb #(
    .XLEN(XLEN), .NB_REG(NB_REG), .NB_WPORT(NB_WPORT), .NB_RPORT(NB_RPORT)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .rs_addr(rs_addr), .rs_val(rs_val),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .issue_rd_en(issue_rd_en),
    .pending(pending), .wr_collision(wr_collision), .addr_error(addr_error),
    .regs_flat(regs_flat)
  );

  always #5 aclk = ~aclk;

  int vectors = 0;
  int errors  = 0;

  logic [XLEN-1:0]   m_regs [NB_REG];
  logic [NB_REG-1:0] m_pend;
  logic              m_coll, m_aerr;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NB_REG; k++) m_regs[k] = '0;
    m_pend = '0;
    m_coll = 1'b0;
    m_aerr = 1'b0;
  endtask

  task automatic idle();
    srst = 1'b0; rs_addr = '0;
    wr_valid = '0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    issue_valid = 1'b0; issue_rd_en = 1'b0;
    issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_valid[p] = 1'b1;
    wr_addr[p*5 +: 5] = a;
    wr_data[p*XLEN +: XLEN] = d;
    wr_strb[p*4 +: 4] = s;
  endtask

  function automatic logic [W-1:0] flat_model();
    logic [W-1:0] f;
    for (int k = 0; k < NB_REG; k++) f[k*XLEN +: XLEN] = m_regs[k];
    return f;
  endfunction

  // One clock: check combinational outputs against the model, advance, check state.
  task automatic cycle();
    logic [XLEN-1:0]   nregs [NB_REG];
    logic [NB_REG-1:0] claimed, view, npend;
    logic [XLEN-1:0]   exp;
    logic              ncoll, naerr, rdy;
    int                a, r1, r2, rd;
    #1;
    for (int k = 0; k < NB_REG; k++) nregs[k] = m_regs[k];
    claimed = '0; ncoll = 1'b0; naerr = 1'b0;
    for (int i = 0; i < NB_WPORT; i++) begin
      if (wr_valid[i]) begin
        a = int'(wr_addr[i*5 +: 5]);
        if (a >= NB_REG) naerr = 1'b1;
        else if (a != 0) begin
          if (claimed[a]) ncoll = 1'b1;
          else begin
            claimed[a] = 1'b1;
            for (int b = 0; b < 4; b++)
              if (wr_strb[i*4 + b]) nregs[a][b*8 +: 8] = wr_data[i*XLEN + b*8 +: 8];
          end
        end
      end
    end
    for (int p = 0; p < NB_RPORT; p++) begin
      a = int'(rs_addr[p*5 +: 5]);
      exp = '0;
      if (a < NB_REG) exp = BYPASS ? nregs[a] : m_regs[a];
      chk($sformatf("rs_val[%0d]", p), W'(rs_val[p*XLEN +: XLEN]), W'(exp));
    end
    view = BYPASS ? (m_pend & ~claimed) : m_pend;
    r1 = int'(issue_rs1); r2 = int'(issue_rs2); rd = int'(issue_rd);
    rdy = 1'b0;
    if (r1 < NB_REG && r2 < NB_REG && rd < NB_REG)
      rdy = !view[r1] && !view[r2] && (!issue_rd_en || !view[rd]);
    chk("issue_ready", W'(issue_ready), W'(rdy));
    npend = m_pend & ~claimed;
    if (issue_valid && rdy && issue_rd_en && rd != 0) npend[rd] = 1'b1;
    if (srst) begin
      for (int k = 0; k < NB_REG; k++) nregs[k] = '0;
      npend = '0; ncoll = 1'b0; naerr = 1'b0;
    end
    @(posedge aclk);
    #1;
    for (int k = 0; k < NB_REG; k++) m_regs[k] = nregs[k];
    m_pend = npend; m_coll = ncoll; m_aerr = naerr;
    chk("pending", W'(pending), W'(m_pend));
    chk("wr_collision", W'(wr_collision), W'(m_coll));
    chk("addr_error", W'(addr_error), W'(m_aerr));
    chk("regs_flat", regs_flat, flat_model());
  endtask

  initial begin
    idle();
    model_reset();
    #12 aresetn = 1'b1;
    @(posedge aclk);
    #1;
    chk("reset_pending", W'(pending), '0);
    chk("reset_regs", regs_flat, '0);
    cycle();

    // Full write, visible next cycle.
    wr(0, 5'd5, 32'hDEADBEEF, 4'hF); rs_addr[0 +: 5] = 5'd5;
    cycle();
    idle(); rs_addr[0 +: 5] = 5'd5; #1;
    chk("wr5_read", W'(rs_val[0 +: XLEN]), W'(32'hDEADBEEF));
    cycle();

    // x0 is never written nor pending.
    wr(0, 5'd0, 32'h12345678, 4'hF);
    cycle();
    idle(); #1;
    chk("x0_read", W'(rs_val[0 +: XLEN]), '0);
    chk("x0_pending", W'(pending[0]), '0);
    cycle();

    // Collision: port 0 wins, flag pulses one cycle.
    wr(0, 5'd7, 32'h11111111, 4'hF); wr(1, 5'd7, 32'h22222222, 4'hF);
    cycle();
    idle(); rs_addr[5 +: 5] = 5'd7; #1;
    chk("coll_data", W'(rs_val[XLEN +: XLEN]), W'(32'h11111111));
    chk("coll_flag", W'(wr_collision), W'(1'b1));
    cycle();
    chk("coll_drop", W'(wr_collision), '0);

    // Out-of-range write is dropped and flagged.
    idle(); wr(1, 5'd20, 32'h55555555, 4'hF);
    cycle();
    chk("aerr_flag", W'(addr_error), W'(1'b1));
    idle();
    cycle();

    // Scoreboard: reserve x3, block a reader, release with a write.
    issue_valid = 1'b1; issue_rd_en = 1'b1; issue_rd = 5'd3;
    cycle();
    chk("pend3_set", W'(pending[3]), W'(1'b1));
    idle(); issue_valid = 1'b1; issue_rs1 = 5'd3; #1;
    chk("rs1_blocked", W'(issue_ready), '0);
    cycle();
    wr(0, 5'd3, 32'hCAFEF00D, 4'hF); #1;
    chk("rs1_same_cycle", W'(issue_ready), W'(BYPASS));
    cycle();
    wr_valid = '0; #1;
    chk("pend3_clr", W'(pending[3]), '0);
    chk("rs1_free", W'(issue_ready), W'(1'b1));
    cycle();

    // Partial strobe merges bytes.
    idle(); wr(0, 5'd9, 32'hAABBCCDD, 4'hF);
    cycle();
    wr(0, 5'd9, 32'h00000011, 4'h1);
    cycle();
    idle(); rs_addr[10 +: 5] = 5'd9; #1;
    chk("strb_merge", W'(rs_val[2*XLEN +: XLEN]), W'(32'hAABBCC11));
    cycle();

    // Synchronous reset overrides a write and an issue in the same cycle.
    wr(0, 5'd2, 32'h0BADF00D, 4'hF); issue_valid = 1'b1; issue_rd_en = 1'b1; issue_rd = 5'd6;
    srst = 1'b1;
    cycle();
    idle();
    cycle();

    // Asynchronous reset mid-cycle clears everything immediately.
    wr(0, 5'd5, 32'h01020304, 4'hF);
    cycle();
    idle(); issue_valid = 1'b1; issue_rd_en = 1'b1; issue_rd = 5'd4;
    cycle();
    chk("pend4_set", W'(pending[4]), W'(1'b1));
    idle();
    rs_addr = {5'd3, 5'd9, 5'd7, 5'd5};
    #2 aresetn = 1'b0;
    #1;
    chk("arst_pending", W'(pending), '0);
    for (int p = 0; p < NB_RPORT; p++)
      chk($sformatf("arst_rs_val[%0d]", p), W'(rs_val[p*XLEN +: XLEN]), '0);
    model_reset();
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    issue_rs1 = 5'd4; issue_rs2 = 5'd3; issue_rd = 5'd4; issue_rd_en = 1'b1;
    cycle();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      idle();
      srst = ($urandom_range(0, 39) == 0);
      for (int p = 0; p < NB_RPORT; p++) rs_addr[p*5 +: 5] = 5'($urandom_range(0, 17));
      for (int i = 0; i < NB_WPORT; i++) begin
        wr_valid[i] = $urandom_range(0, 1) == 1;
        wr_addr[i*5 +: 5] = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 3))
                                                        : 5'($urandom_range(0, 19));
        wr_data[i*XLEN +: XLEN] = $urandom;
        wr_strb[i*4 +: 4] = 4'($urandom_range(0, 15));
      end
      issue_valid = $urandom_range(0, 3) != 0;
      issue_rd_en = $urandom_range(0, 1) == 1;
      issue_rs1 = 5'($urandom_range(0, 16));
      issue_rs2 = 5'($urandom_range(0, 16));
      issue_rd  = 5'($urandom_range(0, 16));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/friscv_regfile_sb.md
FRISCV_REGFILE_SB -- requirements
Module: friscv_regfile_sb

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, register width (multiple of 8); NB_REG, default 32, register count (16 or 32); NB_WPORT, default 2, write port count (1-4); NB_RPORT, default 4, read port count (1-8).
REQ-002 The design SHALL use one clock and an asynchronous active-low reset; the ports are aclk and aresetn.
REQ-003 Ports SHALL be: aclk in 1, clock; aresetn in 1, async active-low reset; srst in 1, synchronous reset.
REQ-004 Ports SHALL be: rs_addr in NB_RPORT*5, read addresses; rs_val out NB_RPORT*XLEN, read data.
REQ-005 Ports SHALL be: wr_valid in NB_WPORT; wr_addr in NB_WPORT*5; wr_data in NB_WPORT*XLEN; wr_strb in NB_WPORT*XLEN/8, byte enables.
REQ-006 Ports SHALL be: issue_valid in 1; issue_ready out 1; issue_rs1, issue_rs2, issue_rd in 5 each; issue_rd_en in 1, instruction writes rd.
REQ-007 Ports SHALL be: pending out NB_REG, scoreboard bits; wr_collision out 1; addr_error out 1; regs_flat out NB_REG*XLEN, debug view of all registers.

Function
REQ-008 Each read port SHALL return regs[rs_addr] combinationally; an address >= NB_REG SHALL read 0.
REQ-009 Register 0 SHALL always read 0, never be written and never be pending.
REQ-010 On a rising edge with wr_valid[i], each byte j SHALL be written where wr_strb[i][j]=1; other bytes SHALL hold.
REQ-011 When several write ports target the same nonzero address in one cycle, the lowest port index SHALL win alone, and wr_collision SHALL pulse high for exactly one cycle on the next edge.
REQ-012 A write with wr_addr >= NB_REG SHALL be dropped, and addr_error SHALL pulse high for one cycle on the next edge.
REQ-013 issue_ready SHALL be high iff pending[issue_rs1]=0, pending[issue_rs2]=0 and (issue_rd_en=0 or pending[issue_rd]=0); any issue address >= NB_REG SHALL force issue_ready low.
REQ-014 A handshake issue_valid && issue_ready with issue_rd_en && issue_rd != 0 SHALL set pending[issue_rd] on the next edge.
REQ-015 Any accepted write to register k SHALL clear pending[k] on the next edge, even when only some wr_strb bits are set.
REQ-016 issue_ready SHALL depend on issue_valid only through the address fields (no combinational loop through issue_valid).
REQ-017 A set and a clear of the same pending bit in the same cycle SHALL resolve to set.

Reset
REQ-018 When aresetn is low (immediately) or srst is high (on the edge), all registers, pending, wr_collision and addr_error SHALL be 0; srst SHALL override writes and issues in that cycle.
REQ-019 Reset asserted mid-operation SHALL discard all reservations; issue_ready SHALL be 1 for any legal addresses after reset.

Configuration
REQ-020 With macro FRISCV_REGFILE_BYPASS_EN defined, a read port whose address matches an accepted same-cycle write SHALL return the merged write data (strobed bytes new, others old), and a pending bit cleared in the same cycle SHALL not block issue_ready.
REQ-021 Without FRISCV_REGFILE_BYPASS_EN, reads and issue_ready SHALL reflect only registered state, giving one cycle of write-to-read latency.

Verification
REQ-022 Reset, then wr_valid[0], addr 5, data 0xDEADBEEF, strb 0xF -> rs_val for addr 5 = 0xDEADBEEF on the following cycle.
REQ-023 Write addr 0, data 0x12345678 -> x0 reads 0 and pending[0] stays 0.
REQ-024 Port0 and port1 both write addr 7, with 0x11111111 and 0x22222222 -> regs[7] = 0x11111111 and wr_collision high for one cycle.
REQ-025 Issue rd=3, then issue rs1=3 -> issue_ready = 0; write addr 3 -> pending[3] clears and issue_ready = 1 (same cycle with bypass, next cycle without).
REQ-026 Write addr 9, 0xAABBCCDD, strb 0xF, then 0x00000011, strb 0x1 -> regs[9] = 0xAABBCC11.
REQ-027 Set pending[4], then pulse aresetn low mid-cycle -> pending = 0 and all rs_val = 0 immediately.
